// File: rtl/core_alu_arbiter.sv
// Two-requester front end for the shared core_alu. It grants one operation at a time,
// drives the one-hot ALU op lines for one cycle, waits ALU_LAT cycles, and routes the
// captured result back to the requester that issued the operation.
module core_alu_arbiter #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        r0_req_valid,
  output logic        r0_req_ready,
  input  logic [5:0]  r0_req_op,
  input  logic [31:0] r0_req_rs1,
  input  logic [31:0] r0_req_rs2,
  input  logic [31:0] r0_req_imm,
  output logic        r0_rsp_valid,
  input  logic        r0_rsp_ready,
  output logic [31:0] r0_rsp_data,
  output logic        r0_rsp_err,

  input  logic        r1_req_valid,
  output logic        r1_req_ready,
  input  logic [5:0]  r1_req_op,
  input  logic [31:0] r1_req_rs1,
  input  logic [31:0] r1_req_rs2,
  input  logic [31:0] r1_req_imm,
  output logic        r1_rsp_valid,
  input  logic        r1_rsp_ready,
  output logic [31:0] r1_rsp_data,
  output logic        r1_rsp_err,

  output logic [32:0] alu_op,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_rs2,
  output logic [31:0] alu_imm,
  input  logic [31:0] alu_result,

  output logic        busy
);

  localparam logic [5:0] LAST_LEGAL_OP = 6'd32;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WAIT,
    RESP
  } state_e;

  state_e      state_q;
  logic        owner_q;
  logic        last_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic [31:0] imm_q;
  logic [31:0] data_q;
  logic        err_q;
  logic [2:0]  cnt_q;
  logic [32:0] alu_op_q;

  logic [1:0]  req_v;
  logic        gnt_any;
  logic        gnt_idx;
  logic [5:0]  sel_op;
  logic [31:0] sel_rs1;
  logic [31:0] sel_rs2;
  logic [31:0] sel_imm;
  logic        owner_rsp_ready;

  // Round-robin on ties: the requester that did not win last time goes first.
  // NOTE: every signal assigned in always_comb gets a value on every path (defaults
  // first), otherwise synthesis infers a latch.
  always_comb begin
    req_v   = {r1_req_valid, r0_req_valid};
    gnt_any = 1'b0;
    gnt_idx = 1'b0;
    if ((state_q == IDLE) && !rst && (req_v != 2'b00)) begin
      gnt_any = 1'b1;
      gnt_idx = (req_v == 2'b11) ? ~last_q : req_v[1];
    end
  end

  assign r0_req_ready = gnt_any & ~gnt_idx;
  assign r1_req_ready = gnt_any &  gnt_idx;

  assign sel_op  = gnt_idx ? r1_req_op  : r0_req_op;
  assign sel_rs1 = gnt_idx ? r1_req_rs1 : r0_req_rs1;
  assign sel_rs2 = gnt_idx ? r1_req_rs2 : r0_req_rs2;
  assign sel_imm = gnt_idx ? r1_req_imm : r0_req_imm;

  assign owner_rsp_ready = owner_q ? r1_rsp_ready : r0_rsp_ready;

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order in this block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      alu_op_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_any) begin
            owner_q <= gnt_idx;
            last_q  <= gnt_idx;
            rs1_q   <= sel_rs1;
            rs2_q   <= sel_rs2;
            imm_q   <= sel_imm;
            data_q  <= '0;
            if (sel_op <= LAST_LEGAL_OP) begin
              err_q    <= 1'b0;
              alu_op_q <= 33'd1 << sel_op;
              state_q  <= EXEC;
            end else begin
              // Illegal opcode: answer immediately, the ALU is never touched.
              err_q   <= 1'b1;
              state_q <= RESP;
            end
          end
        end
        EXEC: begin
          alu_op_q <= '0;
          cnt_q    <= 3'(ALU_LAT);
          state_q  <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            data_q  <= alu_result;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (owner_rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_op  = alu_op_q;
  assign alu_rs1 = rs1_q;
  assign alu_rs2 = rs2_q;
  assign alu_imm = imm_q;

  // Response payload is forced to zero on a port whenever that port is not valid.
  assign r0_rsp_valid = (state_q == RESP) & ~owner_q;
  assign r1_rsp_valid = (state_q == RESP) &  owner_q;
  assign r0_rsp_data  = r0_rsp_valid ? data_q : '0;
  assign r1_rsp_data  = r1_rsp_valid ? data_q : '0;
  assign r0_rsp_err   = r0_rsp_valid & err_q;
  assign r1_rsp_err   = r1_rsp_valid & err_q;

  assign busy = (state_q != IDLE);

endmodule
